bbox_pixel_scanner: RTL and testbench

Consumes one rounded bounding box (XMIN/XMAX/YMIN/YMAX, Q10.6 fixed point) per triangle from the bounding-box stage. Walks every integer pixel inside the box in row-major order and emits one pixel coordinate per accepted handshake to the downstream edge-test/shading stage. It is the reader side of the bounding-box interface, with valid/ready flow control on both input and output.

---
 rtl/bbox_pkg.sv | 23 ++
 rtl/bbox_pixel_scanner_if.sv | 15 +
 rtl/bbox_axis_counter.sv | 36 +++
 rtl/bbox_pixel_scanner.sv | 129 ++++++++++++
 tb/tb_bbox_pixel_scanner.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bbox_pkg.sv
// Shared constants, scan-state encoding and fixed-point helpers for the bounding-box pixel scanner.
package bbox_pkg;

    localparam int COORD_W   = 16;
    localparam int FRAC_BITS = 6;
    localparam int PIX_W     = COORD_W - FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    // Inputs arrive pre-rounded, so the fraction is simply dropped.
    function automatic logic [PIX_W-1:0] to_pix(input logic [COORD_W-1:0] coord);
        return PIX_W'(coord >> FRAC_BITS);
    endfunction

    function automatic logic [COORD_W-1:0] to_sample(input logic [PIX_W-1:0] pix);
        return {pix, 1'b1, {(FRAC_BITS-1){1'b0}}};
    endfunction

endpackage

// File: rtl/bbox_pixel_scanner_if.sv
// Bounding-box handoff channel: one Q10.6 box per valid/ready handshake from the bounding-box stage.
interface bbox_pixel_scanner_if;
    import bbox_pkg::*;

    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
    logic               box_valid;
    logic               box_ready;

    modport master (output xmin, xmax, ymin, ymax, box_valid, input box_ready);
    modport slave  (input xmin, xmax, ymin, ymax, box_valid, output box_ready);

endinterface

// File: rtl/bbox_axis_counter.sv
// One scan axis: loads [min,max] at box accept, then steps and reloads min after reaching max.
module bbox_axis_counter
    import bbox_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PIX_W-1:0] load_min,
    input  logic [PIX_W-1:0] load_max,
    input  logic             step,
    output logic [PIX_W-1:0] value,
    output logic             at_max
);

    logic [PIX_W-1:0] min_q;
    logic [PIX_W-1:0] max_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            min_q <= '0;
            max_q <= '0;
        end else if (load) begin
            value <= load_min;
            min_q <= load_min;
            max_q <= load_max;
        end else if (step) begin
            value <= at_max ? min_q : value + PIX_W'(1);
        end
    end

    // Compared before any increment, so a max of all-ones never overflows.
    assign at_max = (value == max_q);

endmodule

// File: rtl/bbox_pixel_scanner.sv
// Walks every integer pixel of an accepted bounding box in row-major order, one pixel per handshake.
// Define BBOX_CLIP_EN to clamp each box to the SCREEN_W x SCREEN_H screen at accept time.
module bbox_pixel_scanner
    import bbox_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    bbox_pixel_scanner_if.slave box,
    output logic [PIX_W-1:0]   pix_x,
    output logic [PIX_W-1:0]   pix_y,
    output logic [COORD_W-1:0] pix_sx,
    output logic [COORD_W-1:0] pix_sy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               scan_done
);

    if (SCREEN_W < 1 || SCREEN_W > (1 << PIX_W) || SCREEN_H < 1 || SCREEN_H > (1 << PIX_W)) begin : g_bad_screen
        $error("bbox_pixel_scanner: screen size does not fit the pixel coordinate width");
    end

    scan_state_t      state;
    logic             box_ready_q;
    logic             pix_valid_q;
    logic             scan_done_q;
    logic [PIX_W-1:0] xmin_pix, xmax_pix, ymin_pix, ymax_pix;
    logic [PIX_W-1:0] xmax_eff, ymax_eff;
    logic [PIX_W-1:0] x_val, y_val;
    logic             x_at_max, y_at_max;
    logic             box_accept, box_empty, pix_fire, at_last;

    assign xmin_pix = to_pix(box.xmin);
    assign xmax_pix = to_pix(box.xmax);
    assign ymin_pix = to_pix(box.ymin);
    assign ymax_pix = to_pix(box.ymax);

`ifdef BBOX_CLIP_EN
    localparam logic [PIX_W-1:0] X_LIMIT = PIX_W'(SCREEN_W - 1);
    localparam logic [PIX_W-1:0] Y_LIMIT = PIX_W'(SCREEN_H - 1);

    // A box starting off-screen ends up with min > clamped max and is treated as empty.
    assign xmax_eff = (xmax_pix > X_LIMIT) ? X_LIMIT : xmax_pix;
    assign ymax_eff = (ymax_pix > Y_LIMIT) ? Y_LIMIT : ymax_pix;
`else
    assign xmax_eff = xmax_pix;
    assign ymax_eff = ymax_pix;
`endif

    assign box_accept = box.box_valid & box_ready_q & (state == IDLE);
    assign box_empty  = (xmin_pix > xmax_eff) | (ymin_pix > ymax_eff);
    assign pix_fire   = pix_valid_q & pix_ready;
    assign at_last    = x_at_max & y_at_max;

    bbox_axis_counter u_x_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (box_accept),
        .load_min (xmin_pix),
        .load_max (xmax_eff),
        .step     (pix_fire & ~at_last),
        .value    (x_val),
        .at_max   (x_at_max)
    );

    bbox_axis_counter u_y_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (box_accept),
        .load_min (ymin_pix),
        .load_max (ymax_eff),
        .step     (pix_fire & x_at_max & ~y_at_max),
        .value    (y_val),
        .at_max   (y_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            box_ready_q <= 1'b0;
            pix_valid_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (box_accept) begin
                        box_ready_q <= 1'b0;
                        if (box_empty) begin
                            state       <= DONE;
                            scan_done_q <= 1'b1;
                        end else begin
                            state       <= SCAN;
                            pix_valid_q <= 1'b1;
                        end
                    end else begin
                        box_ready_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (pix_fire && at_last) begin
                        state       <= DONE;
                        pix_valid_q <= 1'b0;
                        scan_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    box_ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign box.box_ready = box_ready_q;
    assign pix_valid     = pix_valid_q;
    assign scan_done     = scan_done_q;
    assign pix_last      = pix_valid_q & at_last;
    assign pix_x         = x_val;
    assign pix_y         = y_val;
    // Sample points read as zero when no pixel is offered, matching the reset state.
    assign pix_sx        = pix_valid_q ? to_sample(x_val) : '0;
    assign pix_sy        = pix_valid_q ? to_sample(y_val) : '0;

endmodule

// File: tb/tb_bbox_pixel_scanner.sv
// Scoreboard bench for bbox_pixel_scanner: a reference walk of each box queues expected pixels,
// which are popped as the scanner hands them over; honours BBOX_CLIP_EN when it is defined.
module tb_bbox_pixel_scanner;
    import bbox_pkg::*;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct {
        logic [PIX_W-1:0]   x;
        logic [PIX_W-1:0]   y;
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic               last;
    } pix_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [PIX_W-1:0]   pix_x, pix_y;
    logic [COORD_W-1:0] pix_sx, pix_sy;
    logic               pix_valid, pix_ready, pix_last, scan_done;

    bbox_pixel_scanner_if box_bus ();

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bbox_pixel_scanner #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .box       (box_bus),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_sx    (pix_sx),
        .pix_sy    (pix_sy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .scan_done (scan_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference walk of the box; pushes every expected pixel and returns how many.
    task automatic model_box(input logic [15:0] xmn, xmx, ymn, ymx, output int n);
        int   x0, x1, y0, y1;
        pix_t p;
        x0 = int'(xmn) / 64;
        x1 = int'(xmx) / 64;
        y0 = int'(ymn) / 64;
        y1 = int'(ymx) / 64;
`ifdef BBOX_CLIP_EN
        if (x1 > SCREEN_W - 1) x1 = SCREEN_W - 1;
        if (y1 > SCREEN_H - 1) y1 = SCREEN_H - 1;
`endif
        n = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                p.x    = PIX_W'(x);
                p.y    = PIX_W'(y);
                p.sx   = COORD_W'(x * 64 + 32);
                p.sy   = COORD_W'(y * 64 + 32);
                p.last = (x == x1) && (y == y1);
                exp_q.push_back(p);
                n++;
            end
        end
    endtask

    // Offers one box, then consumes pixels with stall_pct% random back-pressure while
    // throwing junk onto the box channel. abort_after>0 pulses rst after that many pixels.
    task automatic run_box(input logic [15:0] xmn, xmx, ymn, ymx,
                           input int stall_pct, input int abort_after, input string tag);
        int               n_exp, fired, cyc, budget;
        bit               done_seen, held;
        logic [PIX_W-1:0] hx, hy;
        logic             hl;
        pix_t             e;
        fired     = 0;
        done_seen = 1'b0;
        held      = 1'b0;
        hx        = '0;
        hy        = '0;
        hl        = 1'b0;
        cyc       = 0;
        while (!box_bus.box_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " box_ready"}, 32'(box_bus.box_ready), 32'd1);
        model_box(xmn, xmx, ymn, ymx, n_exp);
        budget = n_exp * 8 + 20;

        box_bus.xmin      = xmn;
        box_bus.xmax      = xmx;
        box_bus.ymin      = ymn;
        box_bus.ymax      = ymx;
        box_bus.box_valid = 1'b1;
        @(negedge clk);
        box_bus.box_valid = 1'b0;
        box_bus.xmin      = 16'($urandom);
        box_bus.ymax      = 16'($urandom);
        check({tag, " first_valid"}, 32'(pix_valid), 32'(n_exp > 0));

        cyc = 1;
        while (!done_seen && cyc <= budget) begin
            if (held) begin
                check({tag, " stall_valid"}, 32'(pix_valid), 32'd1);
                check({tag, " stall_x"}, 32'(pix_x), 32'(hx));
                check({tag, " stall_y"}, 32'(pix_y), 32'(hy));
                check({tag, " stall_last"}, 32'(pix_last), 32'(hl));
            end
            held = 1'b0;

            if (abort_after > 0 && fired == abort_after) begin
                rst               = 1'b1;
                pix_ready         = 1'b0;
                box_bus.box_valid = 1'b0;
                @(negedge clk);
                check({tag, " rst_valid"}, 32'(pix_valid), 32'd0);
                check({tag, " rst_done"}, 32'(scan_done), 32'd0);
                check({tag, " rst_ready"}, 32'(box_bus.box_ready), 32'd0);
                rst = 1'b0;
                @(negedge clk);
                check({tag, " post_rst_ready"}, 32'(box_bus.box_ready), 32'd1);
                check({tag, " post_rst_valid"}, 32'(pix_valid), 32'd0);
                check({tag, " post_rst_done"}, 32'(scan_done), 32'd0);
                exp_q.delete();
                return;
            end

            if (scan_done) begin
                done_seen         = 1'b1;
                box_bus.box_valid = 1'b0;
                check({tag, " count"}, 32'(fired), 32'(n_exp));
                check({tag, " done_valid"}, 32'(pix_valid), 32'd0);
                check({tag, " done_last"}, 32'(pix_last), 32'd0);
                if (stall_pct == 0)
                    check({tag, " latency"}, 32'(cyc), 32'(n_exp + 1));
            end else begin
                pix_ready         = ($urandom_range(0, 99) >= stall_pct);
                box_bus.box_valid = 1'($urandom_range(0, 1));
                box_bus.xmin      = 16'($urandom);
                box_bus.xmax      = 16'($urandom);
                box_bus.ymin      = 16'($urandom);
                box_bus.ymax      = 16'($urandom);
                if (pix_valid && pix_ready) begin
                    check({tag, " pending"}, 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check({tag, " x"}, 32'(pix_x), 32'(e.x));
                        check({tag, " y"}, 32'(pix_y), 32'(e.y));
                        check({tag, " sx"}, 32'(pix_sx), 32'(e.sx));
                        check({tag, " sy"}, 32'(pix_sy), 32'(e.sy));
                        check({tag, " last"}, 32'(pix_last), 32'(e.last));
                    end
                    fired++;
                end else if (pix_valid) begin
                    held = 1'b1;
                    hx   = pix_x;
                    hy   = pix_y;
                    hl   = pix_last;
                end
                @(negedge clk);
                cyc++;
            end
        end

        check({tag, " scan_done_seen"}, 32'(done_seen), 32'd1);
        box_bus.box_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check({tag, " ready_after_done"}, 32'(box_bus.box_ready), 32'd1);
        check({tag, " done_pulse"}, 32'(scan_done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x0, x1, y0, y1, t;
        rst               = 1'b1;
        pix_ready         = 1'b0;
        box_bus.box_valid = 1'b0;
        box_bus.xmin      = '0;
        box_bus.xmax      = '0;
        box_bus.ymin      = '0;
        box_bus.ymax      = '0;
        repeat (3) @(negedge clk);
        check("reset box_ready", 32'(box_bus.box_ready), 32'd0);
        check("reset pix_valid", 32'(pix_valid), 32'd0);
        check("reset pix_last", 32'(pix_last), 32'd0);
        check("reset scan_done", 32'(scan_done), 32'd0);
        check("reset pix_x", 32'(pix_x), 32'd0);
        check("reset pix_y", 32'(pix_y), 32'd0);
        check("reset pix_sx", 32'(pix_sx), 32'd0);
        check("reset pix_sy", 32'(pix_sy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle box_ready", 32'(box_bus.box_ready), 32'd1);

        run_box(16'h0080, 16'h0100, 16'h0040, 16'h0080, 0, 0, "t1_basic");
        run_box(16'h0140, 16'h0140, 16'h0140, 16'h0140, 0, 0, "t2_single");
        run_box(16'h0080, 16'h0100, 16'h0040, 16'h0080, 40, 0, "t3_stall");
        run_box(16'h0100, 16'h0080, 16'h0040, 16'h0080, 0, 0, "t4_empty_x");
        run_box(16'h0040, 16'h0080, 16'h0100, 16'h0080, 0, 0, "t4_empty_y");
        run_box(16'h0080, 16'h0100, 16'h0040, 16'h0080, 0, 3, "t5_abort");
        run_box(16'h0080, 16'h0100, 16'h0040, 16'h0080, 0, 0, "t5_rescan");
        run_box(16'h9F80, 16'hAF00, 16'h0000, 16'h0000, 0, 0, "t6_clip");
        run_box(16'hFF00, 16'hFFC0, 16'hFF80, 16'hFFFF, 20, 0, "edge_max");
        run_box(16'h0000, 16'h003F, 16'h0000, 16'h003F, 0, 0, "origin");

        for (int i = 0; i < 10; i++) begin
            x0 = int'($urandom_range(0, 1023));
            x1 = x0 + int'($urandom_range(0, 4));
            if (x1 > 1023) x1 = 1023;
            y0 = int'($urandom_range(0, 1023));
            y1 = y0 + int'($urandom_range(0, 3));
            if (y1 > 1023) y1 = 1023;
            if (i == 4) begin
                t  = x0;
                x0 = x1 + 1;
                x1 = t;
                if (x0 > 1023) x0 = 1023;
            end
            run_box(16'((x0 << 6) | int'($urandom_range(0, 63))),
                    16'((x1 << 6) | int'($urandom_range(0, 63))),
                    16'((y0 << 6) | int'($urandom_range(0, 63))),
                    16'((y1 << 6) | int'($urandom_range(0, 63))),
                    30, 0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
